alu_exec_unit: RTL

//  Execute stage consuming the 3-bit ALU control code (ALUctrlbits) plus two operands; produces result and zero flag.

---
 rtl/alu_exec_unit_pkg.sv | 28 ++
 rtl/alu_serial_shifter.sv | 45 ++++
 rtl/alu_exec_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execute stage: ALU control codes,
// FSM state encoding and the signed-overflow helper for the add paths.
package alu_exec_unit_pkg;

  // ALU control codes (ALUctrlbits), shared with the control unit
  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_NAND = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SL   = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_BEQ  = 3'b110;
  localparam logic [2:0] ALU_MEM  = 3'b111;

  // Execute-stage FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  // Two's-complement overflow of an addition: operands agree in sign
  // but the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial logical shifter: loads an operand, direction and amount, then
// moves the accumulator one bit per clock. 'last' is high in the cycle
// whose clock edge performs the final shift; 'shifted' is the value the
// accumulator takes at that edge.
module alu_serial_shifter #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              dir,      // 0 = left, 1 = right (zero fill)
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  shifted,
  output logic              last
);

  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_q;

  // One-bit step of the accumulator in the latched direction
  always_comb begin
    shifted = dir_q ? (acc >> 1) : (acc << 1);
    last    = (cnt == SHAMT_W'(1));
  end

  // Load latches operands; afterwards shift once per clock until count is 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      acc   <= din;
      cnt   <= shamt;
      dir_q <= dir;
    end else if (cnt != '0) begin
      acc <= shifted;
      cnt <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage. Single-cycle ops complete at the edge that accepts
// start; shifts run through alu_serial_shifter at one bit per clock.
// Handshake: start is sampled only while busy=0; an accepted op produces
// exactly one done pulse (result/zero valid that cycle), shamt cycles
// later for a non-zero shift and immediately otherwise. start while busy
// is dropped, never queued.
// Optional feature macro: ALU_OVF_FLAG_EN adds the ovf output.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy,
  output logic              done
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic              ovf
`endif
);

  alu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   sum, diff, alu_res;
  logic [DATA_W-1:0]   result_d;
  logic                zero_d, done_d;
  logic                is_shift, shamt_nz;
  logic                sh_load, sh_last;
  logic [DATA_W-1:0]   sh_shifted;
`ifdef ALU_OVF_FLAG_EN
  logic                ovf_d;
`endif

  assign busy = (state_q == ST_SHIFT);

  // Single-cycle datapath on the live operands (used at the accept edge)
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    is_shift = (alu_ctrl == ALU_SL) || (alu_ctrl == ALU_SR);
    shamt_nz = (b[SHAMT_W-1:0] != '0);
    alu_res  = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_res = sum;
      ALU_NAND: alu_res = ~(a & b);
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SL:   alu_res = a;   // only reached with shamt = 0
      ALU_SR:   alu_res = a;
      ALU_BEQ:  alu_res = diff;
      ALU_MEM:  alu_res = sum;
      default:  alu_res = '0;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/SHIFT FSM
  always_comb begin
    state_d  = state_q;
    result_d = result;
    zero_d   = zero;
    done_d   = 1'b0;
    sh_load  = 1'b0;
`ifdef ALU_OVF_FLAG_EN
    ovf_d    = ovf;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift && shamt_nz) begin
            sh_load = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
`ifdef ALU_OVF_FLAG_EN
            ovf_d    = ((alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_MEM)) &&
                       add_ovf(a[DATA_W-1], b[DATA_W-1], sum[DATA_W-1]);
`endif
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          result_d = sh_shifted;
          zero_d   = (sh_shifted == '0);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
`ifdef ALU_OVF_FLAG_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs; async reset aborts any shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      result  <= '0;
      zero    <= 1'b0;
      done    <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      result  <= result_d;
      zero    <= zero_d;
      done    <= done_d;
`ifdef ALU_OVF_FLAG_EN
      ovf     <= ovf_d;
`endif
    end
  end

  alu_serial_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sh_load),
    .dir     (alu_ctrl == ALU_SR),
    .shamt   (b[SHAMT_W-1:0]),
    .din     (a),
    .shifted (sh_shifted),
    .last    (sh_last)
  );

endmodule
